// File: rtl/ahb_lite_master_if.sv
// Local command/data handshake plus AHB-lite bus signals of the single-master AHB-lite master.
interface ahb_lite_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [2:0]  cmd_burst;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        cmd_done;
    logic        cmd_err;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [3:0]  Hprot;
    logic        Hmastlock;
    logic [31:0] Hwdata;
    logic        Hready;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wr_data,
               Hready, Hresp, Hrdata,
        output cmd_ready, wr_pop, rd_valid, rd_data, cmd_done, cmd_err,
               Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wr_data,
               Hready, Hresp, Hrdata,
        input  cmd_ready, wr_pop, rd_valid, rd_data, cmd_done, cmd_err,
               Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Hwdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-lite bus master: turns one local command into a pipelined burst, handling
// wait states, the two-cycle ERROR response and INCR 1KB boundary splitting.
module ahb_lite_master #(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              Hclk,
    input  logic              Hreset,
    ahb_lite_master_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 5;
    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam logic [1:0]  TR_SEQ    = 2'b11;
    localparam logic [2:0]  BU_INCR   = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   haddr_q, haddr_d, hwdata_q, hwdata_d, rd_data_q, rd_data_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [2:0]      hsize_q, hsize_d, hburst_q, hburst_d;
    logic [LW-1:0]   remain_q, remain_d;
    logic            dphase_q, dphase_d, dwrite_q, dwrite_d;
    logic            cmd_ready_q, cmd_ready_d, rd_valid_q, rd_valid_d;
    logic            cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;

    logic [LW-1:0]   cmd_beats_c;
    logic [AW-1:0]   bytes_c, wrap_mask_c, incr_addr_c, next_addr_c, cmd_mask_c;
    logic            is_wrap_c, in_burst_c, addr_go_c, err_first_c, wr_pop_c, rd_beat_c;

    // Beat count of the incoming command
    always_comb begin
        cmd_beats_c = LW'(16);
        case (bus.cmd_burst)
            3'b000:         cmd_beats_c = LW'(1);
            3'b001: begin
                if (bus.cmd_len == '0)                     cmd_beats_c = LW'(1);
                else if (32'(bus.cmd_len) > MAX_LEN)       cmd_beats_c = LW'(MAX_LEN);
                else                                       cmd_beats_c = bus.cmd_len;
            end
            3'b010, 3'b011: cmd_beats_c = LW'(4);
            3'b100, 3'b101: cmd_beats_c = LW'(8);
            default:        cmd_beats_c = LW'(16);
        endcase
    end

    // Next beat address; WRAP bursts wrap inside a beats*bytes aligned window
    always_comb begin
        cmd_mask_c  = (AW'(1) << bus.cmd_size) - AW'(1);
        bytes_c     = AW'(1) << hsize_q;
        incr_addr_c = haddr_q + bytes_c;
        is_wrap_c   = (hburst_q == 3'b010) || (hburst_q == 3'b100) || (hburst_q == 3'b110);
        wrap_mask_c = (bytes_c << (3'(hburst_q[2:1]) + 3'd1)) - AW'(1);
        next_addr_c = is_wrap_c ? ((haddr_q & ~wrap_mask_c) | (incr_addr_c & wrap_mask_c))
                                : incr_addr_c;
    end

    assign in_burst_c  = (state_q == S_ADDR) || (state_q == S_LAST);
    assign addr_go_c   = (state_q == S_ADDR) && bus.Hready;
    assign err_first_c = in_burst_c && dphase_q && bus.Hresp && !bus.Hready;
    assign wr_pop_c    = addr_go_c && hwrite_q;
    assign rd_beat_c   = in_burst_c && dphase_q && !dwrite_q && bus.Hready && !bus.Hresp;

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hwdata_d    = hwdata_q;
        remain_d    = remain_q;
        dphase_d    = dphase_q;
        dwrite_d    = dwrite_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        cmd_ready_d = 1'b0;

        if (rd_beat_c) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.Hrdata;
        end
        if (wr_pop_c) begin
            hwdata_d = bus.wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d  = S_ADDR;
                    haddr_d  = bus.cmd_addr & ~cmd_mask_c;
                    htrans_d = TR_NONSEQ;
                    hwrite_d = bus.cmd_write;
                    hsize_d  = bus.cmd_size;
                    hburst_d = bus.cmd_burst;
                    remain_d = cmd_beats_c - LW'(1);
                    dphase_d = 1'b0;
                end
            end
            S_ADDR: begin
                if (err_first_c) begin
                    htrans_d = TR_IDLE;
                    state_d  = S_ERR;
                end else if (bus.Hready) begin
                    dphase_d = 1'b1;
                    dwrite_d = hwrite_q;
                    if (remain_q != '0) begin
                        haddr_d  = next_addr_c;
                        remain_d = remain_q - LW'(1);
                        // Undefined-length INCR restarts with NONSEQ at each 1KB boundary
                        htrans_d = ((hburst_q == BU_INCR) && (next_addr_c[9:0] == 10'd0))
                                   ? TR_NONSEQ : TR_SEQ;
                    end else begin
                        htrans_d = TR_IDLE;
                        state_d  = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (err_first_c) begin
                    state_d = S_ERR;
                end else if (bus.Hready) begin
                    dphase_d   = 1'b0;
                    cmd_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_ERR: begin
                if (bus.Hready) begin
                    dphase_d   = 1'b0;
                    cmd_done_d = 1'b1;
                    cmd_err_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready only from the cycle after cmd_done
        cmd_ready_d = (state_d == S_IDLE) && !cmd_done_d;
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b010;
            hburst_q    <= 3'b000;
            hwdata_q    <= '0;
            remain_q    <= '0;
            dphase_q    <= 1'b0;
            dwrite_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            remain_q    <= remain_d;
            dphase_q    <= dphase_d;
            dwrite_q    <= dwrite_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_pop    = wr_pop_c;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.cmd_done  = cmd_done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.Haddr     = haddr_q;
    assign bus.Htrans    = htrans_q;
    assign bus.Hwrite    = hwrite_q;
    assign bus.Hsize     = hsize_q;
    assign bus.Hburst    = hburst_q;
    assign bus.Hprot     = HPROT_VAL;
    assign bus.Hmastlock = 1'b0;
    assign bus.Hwdata    = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench for ahb_lite_master: scripted slave, write-data source, and a
// monitor that pops expected address phases, write data, read beats and completions.
module tb_ahb_lite_master;
    logic Hclk;
    logic Hreset;

    ahb_lite_master_if bus ();

    ahb_lite_master #(.MAX_LEN(16), .HPROT_VAL(4'b0011)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int errors;
    int checks;

    logic [33:0] exp_addr_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_rd_q[$];
    logic        exp_done_q[$];

    // slave script
    int          beat_cnt;
    int          wait_beat;
    int          wait_cycles;
    int          err_beat;
    logic [31:0] rd_base;
    // write source
    logic [31:0] wr_vals[16];
    int          wr_idx;
    int          pop_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Scripted slave: wait states and a two-cycle ERROR on chosen beats
    int   s_beat;
    int   s_wait;
    int   s_err;
    logic s_act;
    initial begin
        bus.Hready = 1'b1;
        bus.Hresp  = 1'b0;
        bus.Hrdata = '0;
        s_act = 1'b0; s_wait = 0; s_err = 0; s_beat = 0;
        forever begin
            @(negedge Hclk);
            if (Hreset) begin
                s_act = 1'b0; s_wait = 0; s_err = 0;
            end else if (bus.Hready) begin
                s_act = bus.Htrans[1];
                if (s_act) begin
                    s_beat = beat_cnt;
                    beat_cnt++;
                    s_wait = (s_beat == wait_beat) ? wait_cycles : 0;
                    s_err  = (s_beat == err_beat) ? 1 : 0;
                end else begin
                    s_wait = 0; s_err = 0;
                end
            end else begin
                if (s_wait > 0) s_wait--;
                else if (s_err == 1) s_err = 2;
            end
            @(posedge Hclk);
            #1;
            if (s_act && s_wait > 0)    begin bus.Hready = 1'b0; bus.Hresp = 1'b0; end
            else if (s_act && s_err == 1) begin bus.Hready = 1'b0; bus.Hresp = 1'b1; end
            else if (s_act && s_err == 2) begin bus.Hready = 1'b1; bus.Hresp = 1'b1; end
            else                          begin bus.Hready = 1'b1; bus.Hresp = 1'b0; end
            bus.Hrdata = rd_base + 32'(s_beat);
        end
    end

    // Local write-data source: advances one entry per wr_pop
    initial begin
        forever begin
            @(negedge Hclk);
            if (!Hreset && bus.wr_pop) begin
                pop_cnt++;
                @(posedge Hclk);
                #1;
                wr_idx++;
                bus.wr_data = wr_vals[wr_idx % 16];
            end
        end
    end

    // Monitor / scoreboard
    logic        m_dph, m_dwr, p_act, p_rdy, p_resp, p_dph;
    logic [33:0] p_at;
    initial begin
        m_dph = 1'b0; m_dwr = 1'b0; p_act = 1'b0; p_rdy = 1'b1; p_resp = 1'b0; p_dph = 1'b0; p_at = '0;
        forever begin
            @(negedge Hclk);
            if (Hreset) begin
                m_dph = 1'b0; p_act = 1'b0; p_dph = 1'b0; p_rdy = 1'b1; p_resp = 1'b0;
            end else begin
                if (p_act && !p_rdy && !p_resp)
                    chk("addr_hold", 64'({bus.Htrans, bus.Haddr}), 64'(p_at));
                if (p_dph && p_resp && !p_rdy)
                    chk("err_idle", 64'(bus.Htrans), 64'(0));
                if (bus.Htrans != 2'b00 && bus.Hready) begin
                    if (exp_addr_q.size() == 0) unexpected("addr_phase", 64'({bus.Htrans, bus.Haddr}));
                    else chk("addr_phase", 64'({bus.Htrans, bus.Haddr}), 64'(exp_addr_q.pop_front()));
                end
                if (m_dph && m_dwr && bus.Hready && !bus.Hresp) begin
                    if (exp_wd_q.size() == 0) unexpected("hwdata", 64'(bus.Hwdata));
                    else chk("hwdata", 64'(bus.Hwdata), 64'(exp_wd_q.pop_front()));
                end
                if (bus.rd_valid) begin
                    if (exp_rd_q.size() == 0) unexpected("rd_data", 64'(bus.rd_data));
                    else chk("rd_data", 64'(bus.rd_data), 64'(exp_rd_q.pop_front()));
                end
                if (bus.cmd_done) begin
                    if (exp_done_q.size() == 0) unexpected("cmd_done", 64'(bus.cmd_err));
                    else chk("cmd_err", 64'(bus.cmd_err), 64'(exp_done_q.pop_front()));
                end
                p_act  = (bus.Htrans != 2'b00);
                p_rdy  = bus.Hready;
                p_resp = bus.Hresp;
                p_dph  = m_dph;
                p_at   = {bus.Htrans, bus.Haddr};
                if (bus.Hready) begin
                    m_dph = (bus.Htrans != 2'b00);
                    m_dwr = bus.Hwrite;
                end
            end
        end
    end

    task automatic setup(input logic [31:0] base, input int wb, input int wc, input int eb);
        beat_cnt = 0; wait_beat = wb; wait_cycles = wc; err_beat = eb;
        rd_base = base; pop_cnt = 0; wr_idx = 0;
        bus.wr_data = wr_vals[0];
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [2:0] br, input logic [4:0] len);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge Hclk); #1; n++;
        end
        chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
        bus.cmd_size = sz; bus.cmd_burst = br; bus.cmd_len = len;
        @(posedge Hclk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string name, input int exp_pops);
        int n;
        n = 0;
        while (exp_done_q.size() != 0 && n < 200) begin
            @(posedge Hclk); #1; n++;
        end
        chk({name, "_done_timeout"}, 64'(n < 200), 64'(1));
        repeat (3) @(posedge Hclk);
        #1;
        chk({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'(0));
        chk({name, "_wd_left"},   64'(exp_wd_q.size()),   64'(0));
        chk({name, "_rd_left"},   64'(exp_rd_q.size()),   64'(0));
        chk({name, "_wr_pops"},   64'(pop_cnt),           64'(exp_pops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0;
        beat_cnt = 0; wait_beat = -1; wait_cycles = 0; err_beat = -1; rd_base = '0;
        wr_idx = 0; pop_cnt = 0;
        for (int i = 0; i < 16; i++) wr_vals[i] = '0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_size = 3'd2; bus.cmd_burst = 3'd0; bus.cmd_len = 5'd0; bus.wr_data = '0;
        Hreset = 1'b1;
        repeat (2) @(posedge Hclk);
        #1;
        chk("rst_htrans",    64'(bus.Htrans),    64'(0));
        chk("rst_haddr",     64'(bus.Haddr),     64'(0));
        chk("rst_hwrite",    64'(bus.Hwrite),    64'(0));
        chk("rst_hsize",     64'(bus.Hsize),     64'(3'b010));
        chk("rst_hburst",    64'(bus.Hburst),    64'(0));
        chk("rst_hwdata",    64'(bus.Hwdata),    64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("rst_outs",      64'({bus.wr_pop, bus.rd_valid, bus.cmd_done, bus.cmd_err}), 64'(0));
        chk("rst_rd_data",   64'(bus.rd_data),   64'(0));
        chk("hprot",         64'(bus.Hprot),     64'(4'b0011));
        chk("hmastlock",     64'(bus.Hmastlock), 64'(0));
        Hreset = 1'b0;
        @(posedge Hclk); #1;
        chk("ready_after_rst", 64'(bus.cmd_ready), 64'(1));

        // SINGLE word write at 0x10
        wr_vals[0] = 32'hA5A5_0001;
        setup(32'h0, -1, 0, -1);
        exp_addr_q.push_back({2'b10, 32'h10});
        exp_wd_q.push_back(32'hA5A5_0001);
        exp_done_q.push_back(1'b0);
        issue(1'b1, 32'h10, 3'd2, 3'b000, 5'd0);
        finish_cmd("single_wr", 1);

        // INCR4 word read at 0x00
        setup(32'h1, -1, 0, -1);
        exp_addr_q.push_back({2'b10, 32'h00});
        exp_addr_q.push_back({2'b11, 32'h04});
        exp_addr_q.push_back({2'b11, 32'h08});
        exp_addr_q.push_back({2'b11, 32'h0C});
        for (int i = 1; i <= 4; i++) exp_rd_q.push_back(32'(i));
        exp_done_q.push_back(1'b0);
        issue(1'b0, 32'h0, 3'd2, 3'b011, 5'd0);
        finish_cmd("incr4_rd", 0);

        // WRAP8 word write at 0x34
        for (int i = 0; i < 8; i++) wr_vals[i] = 32'hB000_0000 + 32'(i);
        setup(32'h0, -1, 0, -1);
        exp_addr_q.push_back({2'b10, 32'h34});
        exp_addr_q.push_back({2'b11, 32'h38});
        exp_addr_q.push_back({2'b11, 32'h3C});
        exp_addr_q.push_back({2'b11, 32'h20});
        exp_addr_q.push_back({2'b11, 32'h24});
        exp_addr_q.push_back({2'b11, 32'h28});
        exp_addr_q.push_back({2'b11, 32'h2C});
        exp_addr_q.push_back({2'b11, 32'h30});
        for (int i = 0; i < 8; i++) exp_wd_q.push_back(32'hB000_0000 + 32'(i));
        exp_done_q.push_back(1'b0);
        issue(1'b1, 32'h34, 3'd2, 3'b100, 5'd0);
        finish_cmd("wrap8_wr", 8);

        // INCR4 read with two wait states on beat 2
        setup(32'h100, 1, 2, -1);
        exp_addr_q.push_back({2'b10, 32'h00});
        exp_addr_q.push_back({2'b11, 32'h04});
        exp_addr_q.push_back({2'b11, 32'h08});
        exp_addr_q.push_back({2'b11, 32'h0C});
        for (int i = 0; i < 4; i++) exp_rd_q.push_back(32'h100 + 32'(i));
        exp_done_q.push_back(1'b0);
        issue(1'b0, 32'h0, 3'd2, 3'b011, 5'd0);
        finish_cmd("incr4_wait", 0);

        // INCR halfword read from unaligned 0x3FD, crossing 1KB
        setup(32'h300, -1, 0, -1);
        exp_addr_q.push_back({2'b10, 32'h3FC});
        exp_addr_q.push_back({2'b11, 32'h3FE});
        exp_addr_q.push_back({2'b10, 32'h400});
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(32'h300 + 32'(i));
        exp_done_q.push_back(1'b0);
        issue(1'b0, 32'h3FD, 3'd1, 3'b001, 5'd3);
        finish_cmd("incr_hw_1k", 0);

        // INCR len 4 word read at 0x3F8, ERROR on beat 3
        setup(32'h200, -1, 0, 2);
        exp_addr_q.push_back({2'b10, 32'h3F8});
        exp_addr_q.push_back({2'b11, 32'h3FC});
        exp_addr_q.push_back({2'b10, 32'h400});
        exp_rd_q.push_back(32'h200);
        exp_rd_q.push_back(32'h201);
        exp_done_q.push_back(1'b1);
        issue(1'b0, 32'h3F8, 3'd2, 3'b001, 5'd4);
        finish_cmd("incr_err", 0);

        // Reset in the middle of an INCR8 write
        for (int i = 0; i < 8; i++) wr_vals[i] = 32'hC000_0000 + 32'(i);
        setup(32'h0, -1, 0, -1);
        for (int i = 0; i < 8; i++) exp_addr_q.push_back({(i == 0) ? 2'b10 : 2'b11, 32'h80 + 32'(4 * i)});
        for (int i = 0; i < 8; i++) exp_wd_q.push_back(32'hC000_0000 + 32'(i));
        exp_done_q.push_back(1'b0);
        issue(1'b1, 32'h80, 3'd2, 3'b101, 5'd0);
        repeat (3) @(posedge Hclk);
        #2;
        Hreset = 1'b1;
        #1;
        chk("midrst_htrans", 64'(bus.Htrans),    64'(0));
        chk("midrst_haddr",  64'(bus.Haddr),     64'(0));
        chk("midrst_hwdata", 64'(bus.Hwdata),    64'(0));
        chk("midrst_hwrite", 64'(bus.Hwrite),    64'(0));
        chk("midrst_ready",  64'(bus.cmd_ready), 64'(0));
        chk("midrst_outs",   64'({bus.wr_pop, bus.rd_valid, bus.cmd_done, bus.cmd_err}), 64'(0));
        exp_addr_q.delete(); exp_wd_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b0;

        // SINGLE word read after the abandoned burst
        setup(32'h77, -1, 0, -1);
        exp_addr_q.push_back({2'b10, 32'h44});
        exp_rd_q.push_back(32'h77);
        exp_done_q.push_back(1'b0);
        issue(1'b0, 32'h44, 3'd2, 3'b000, 5'd0);
        finish_cmd("post_rst_single", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
